// File: rtl/jkff_ctrl_pkg.sv
// Shared definitions for the JK-counter run controller: FSM state encoding,
// step-counter width/saturation value and the default timeout limit.
// Imported by jkff_ctrl_timer and jkff_count_ctrl.
package jkff_ctrl_pkg;

  localparam int STEP_W             = 6;
  localparam int STEP_MAX           = (1 << STEP_W) - 1;
  localparam int TIMEOUT_CYCLES_DEF = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/jkff_counter.sv
// 4-bit JK-flip-flop counter used as the controller's load; counts
// 0,1,2,7,8,9,10,15,0,... while stage 0 is driven in toggle mode (j=k=1).
// Ports: clk, rst_n (async active-low clear), j/k (stage-0 drive) -> q.
module jkff_counter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       j,
  input  logic       k,
  output logic [3:0] q
);

  logic       en;
  logic [3:0] sj;
  logic [3:0] sk;

  // Upper stages advance only when stage 0 is toggling.
  assign en    = j & k;
  assign sj[0] = j;
  assign sk[0] = k;
  assign sj[1] = en & q[0];
  assign sk[1] = en & q[0];
  // Stage 2 pulses high for one count after 2 and 10, giving the 2->7 and
  // 10->15 jumps; stage 3 toggles while stage 2 is high.
  assign sj[2] = en & q[1] & ~q[0];
  assign sk[2] = en & q[2];
  assign sj[3] = en & q[2];
  assign sk[3] = en & q[2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else begin
      q <= (sj & ~q) | (~sk & q);
    end
  end

endmodule

// File: rtl/jkff_ctrl_timer.sv
// Saturating count of enabled counter edges plus the run timeout compare.
// Ports: clk, rst (async, active-high), clr (new run accepted), inc (counter
//   enabled this cycle) -> steps (edge count), timeout (limit reached).
// Macro JKFF_COUNT_CTRL_TIMEOUT_EN enables the timeout compare; otherwise
// timeout is tied low and LIMIT only feeds the elaboration range check.
module jkff_ctrl_timer
  import jkff_ctrl_pkg::*;
#(
  parameter int LIMIT = TIMEOUT_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              inc,
  output logic [STEP_W-1:0] steps,
  output logic              timeout
);

  localparam logic [STEP_W-1:0] STEPS_SAT = '1;

  // Catch an out-of-range limit at build time rather than as odd behaviour.
  if (LIMIT < 1 || LIMIT > STEP_MAX) begin : g_bad_limit
    $error("jkff_ctrl_timer: LIMIT must be within 1..63");
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      steps <= '0;
    end else if (clr) begin
      steps <= '0;
    end else if (inc && steps != STEPS_SAT) begin
      steps <= steps + 1'b1;
    end
  end

`ifdef JKFF_COUNT_CTRL_TIMEOUT_EN
  localparam logic [STEP_W-1:0] LIM = LIMIT[STEP_W-1:0];
  assign timeout = (steps >= LIM);
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: rtl/jkff_count_ctrl.sv
// Run controller for an external jkff_counter: on start it clears the counter,
// enables it until it reaches the latched target, then pulses done.
// Ports: clk, rst (async, active-high), start, target -> busy, done, err,
//   steps; counter side: cnt_rst_n, cnt_j, cnt_k out, cnt_q in.
// Macro JKFF_COUNT_CTRL_TIMEOUT_EN adds a TIMEOUT_CYCLES abort with err=1.
module jkff_count_ctrl
  import jkff_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [3:0]        target,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [STEP_W-1:0] steps,
  output logic              cnt_rst_n,
  output logic              cnt_j,
  output logic              cnt_k,
  input  logic [3:0]        cnt_q
);

  state_t     state;
  logic [3:0] target_r;
  logic       busy_r;
  logic       done_r;
  logic       err_r;
  logic       cnt_rst_n_r;
  logic       match;
  logic       timeout;
  logic       accept;
  logic       enable;

  assign match  = (cnt_q == target_r);
  assign accept = (state == IDLE) && start;
  // Enable is combinational from cnt_q so the counter stops on the matching
  // value in the same cycle it appears, never stepping past it.
  assign enable = (state == RUN) && !match && !timeout;

  assign cnt_j     = enable;
  assign cnt_k     = enable;
  assign busy      = busy_r;
  assign done      = done_r;
  assign err       = err_r;
  assign cnt_rst_n = cnt_rst_n_r;

  jkff_ctrl_timer #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (accept),
    .inc     (enable),
    .steps   (steps),
    .timeout (timeout)
  );

  // Outputs are registered alongside the state, each set to the value
  // belonging to the state being entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      target_r    <= '0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
      cnt_rst_n_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      err_r  <= 1'b0;
      case (state)
        IDLE: begin
          cnt_rst_n_r <= 1'b1;
          if (start) begin
            target_r    <= target;
            state       <= CLEAR;
            busy_r      <= 1'b1;
            cnt_rst_n_r <= 1'b0;
          end
        end
        CLEAR: begin
          state       <= RUN;
          cnt_rst_n_r <= 1'b1;
        end
        RUN: begin
          // A match wins over a timeout landing in the same cycle.
          if (match || timeout) begin
            state  <= DONE;
            busy_r <= 1'b0;
            done_r <= 1'b1;
            err_r  <= !match;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state  <= IDLE;
          busy_r <= 1'b0;
        end
      endcase
    end
  end

endmodule
